piece_pos_ctrl: RTL and testbench
=================================

# piece_pos_ctrl

Parametrised successor to the single-step block position register: tracks the falling piece's X/Y position and rotation on a configurable board, runs its own gravity timer, and commits a move only after a bounds check and a collision probe. Sits between the input debouncer/controller and the board memory; the board answers each probe with a one-bit collision result. Reports landing so the line-clear logic can lock the piece and request a respawn.

## Interface
- BOARD_W, 10, playfield columns
- BOARD_H, 20, playfield rows
- X_W, 5, width of X position (must hold 0..BOARD_W-1)
- Y_W, 5, width of Y position (must hold 0..BOARD_H-1)
- SPAWN_X, 5, X loaded on reset/spawn
- SPAWN_Y, 0, Y loaded on reset/spawn
- GRAVITY_DIV, 1000, clk cycles per gravity tick (>=2)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- spawn  in  1  pulse: load spawn position, rot=0, enter ACTIVE
- left / right / rotate / drop  in  1 each  move requests (level, sampled in ACTIVE)
- probe_valid  out  1  candidate position presented to board
- probe_x  out  X_W; probe_y  out  Y_W; probe_rot  out  2  candidate
- collide_valid  in  1  board response strobe (any cycle >=1 after probe_valid rises)
- collide  in  1  1 = candidate overlaps locked cells
- pos_x  out  X_W; pos_y  out  Y_W; rot  out  2  committed piece state
- active  out  1  piece in play (state != IDLE)
- landed  out  1  one-cycle pulse when a downward move is blocked

## Operation
- States: IDLE, ACTIVE, PROBE, LAND. Reset -> IDLE.
- IDLE: ignores moves and gravity; spawn -> load SPAWN_X/SPAWN_Y, rot=0, clear gravity count, -> ACTIVE.
- ACTIVE: select one request by priority gravity-tick/drop > left > right > rotate. Candidate: drop/tick y+1; left x-1; right x+1; rotate (rot+1) mod 4.
- Local bounds check before probing: left at x==0, right at x==BOARD_W-1 -> request dropped, stay ACTIVE, no probe. Down at y==BOARD_H-1 -> LAND without probe. No X_W/Y_W wrap ever committed.
- PROBE: probe_valid=1, probe_* held constant until collide_valid. collide=0 -> commit candidate, -> ACTIVE. collide=1 on down move -> LAND; on left/right/rotate -> discard, -> ACTIVE.
- LAND: landed=1 for one cycle, -> IDLE; pos/rot keep last committed values.
- Gravity: counter runs in ACTIVE and PROBE; reaching GRAVITY_DIV-1 sets a pending-tick flag and reloads 0. Pending tick consumed by next ACTIVE selection; a second tick while pending is merged (never queued twice). drop consumes the pending tick too.
- spawn in ACTIVE/PROBE: aborts any probe (probe_valid drops next cycle, late collide_valid ignored), reloads spawn state.
- Rotation changes rot only; shape bounds beyond the pivot are the board's collision responsibility.

## Timing
- Reset values: pos_x=SPAWN_X, pos_y=SPAWN_Y, rot=0, probe_valid=0, probe_*=0, active=0, landed=0, gravity count 0, pending 0.
- Request sampled in ACTIVE at edge N -> probe_valid high from N+1.
- collide_valid at edge M -> pos/rot updated and probe_valid low at M+1; next request may be sampled at M+1.
- Minimum move latency 2 cycles (board answers in 1). Bounds-rejected move costs 1 cycle in ACTIVE.
- Landing at bottom row: sample at N, landed pulse at N+1, active low at N+2.
- collide_valid outside PROBE ignored.
- rst mid-probe: all state to reset values next edge, no landed pulse.

## Structure
- tetris_pkg: state enum, move-kind enum (MV_DOWN, MV_LEFT, MV_RIGHT, MV_ROT), rotation width constant.
- Sub-module gravity_timer (parameter GRAVITY_DIV; ports clk, rst, en, consume, pending). Remainder in one FSM module.

## Test plan
- Reset then spawn -> pos=(5,0), rot=0, active=1 one cycle after spawn; landed=0.
- left held at x=0 -> no probe_valid, pos_x stays 0; right from x=9 with BOARD_W=10 -> no probe.
- right at (5,3), board answers collide=0 after 3 cycles -> probe (6,3) held 3 cycles, pos_x=6 next cycle.
- drop at (4,7), collide=1 -> landed pulse exactly 1 cycle, pos stays (4,7), active=0 after.
- GRAVITY_DIV=4, no input -> pos_y increments once every 4+probe cycles; left and gravity same cycle -> down wins, left serviced next.
- spawn during outstanding probe, then late collide_valid -> pos=(SPAWN_X,SPAWN_Y), late response ignored.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types for the falling-piece position controller.
package tetris_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_PROBE,
    ST_LAND
  } state_t;

  typedef enum logic [1:0] {
    MV_DOWN,
    MV_LEFT,
    MV_RIGHT,
    MV_ROT
  } move_t;

  localparam int ROT_W = 2;

endpackage

// File: rtl/piece_pos_ctrl_gravity_timer.sv
// Gravity timer: free-running divider that raises a sticky pending-tick flag.
module gravity_timer #(
  parameter int GRAVITY_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic consume,
  output logic pending
);

  localparam int CNT_W = $clog2(GRAVITY_DIV);

  logic [CNT_W-1:0] count;
  logic             wrap;

  assign wrap = en && (count == CNT_W'(GRAVITY_DIV - 1));

  // A wrap arriving while a tick is already pending merges into it; a wrap in
  // the same cycle as a consume leaves exactly one fresh tick pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      pending <= 1'b0;
    end else begin
      if (en) count <= wrap ? '0 : count + 1'b1;
      pending <= wrap | (pending & ~consume);
    end
  end

endmodule

// File: rtl/piece_pos_ctrl.sv
// Falling-piece position/rotation register with bounds check, board collision
// probe handshake, gravity timer and landing report.
module piece_pos_ctrl
  import tetris_pkg::*;
#(
  parameter int BOARD_W     = 10,
  parameter int BOARD_H     = 20,
  parameter int X_W         = 5,
  parameter int Y_W         = 5,
  parameter int SPAWN_X     = 5,
  parameter int SPAWN_Y     = 0,
  parameter int GRAVITY_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spawn,
  input  logic             left,
  input  logic             right,
  input  logic             rotate,
  input  logic             drop,
  output logic             probe_valid,
  output logic [X_W-1:0]   probe_x,
  output logic [Y_W-1:0]   probe_y,
  output logic [ROT_W-1:0] probe_rot,
  input  logic             collide_valid,
  input  logic             collide,
  output logic [X_W-1:0]   pos_x,
  output logic [Y_W-1:0]   pos_y,
  output logic [ROT_W-1:0] rot,
  output logic             active,
  output logic             landed
);

  localparam logic [X_W-1:0] X_MAX   = X_W'(BOARD_W - 1);
  localparam logic [Y_W-1:0] Y_MAX   = Y_W'(BOARD_H - 1);
  localparam logic [X_W-1:0] X_SPAWN = X_W'(SPAWN_X);
  localparam logic [Y_W-1:0] Y_SPAWN = Y_W'(SPAWN_Y);

  state_t             state, state_nxt;
  move_t              kind, kind_nxt;
  logic [X_W-1:0]     pos_x_nxt, probe_x_nxt;
  logic [Y_W-1:0]     pos_y_nxt, probe_y_nxt;
  logic [ROT_W-1:0]   rot_nxt, probe_rot_nxt;
  logic               consume, pending, grav_en, timer_rst;

  assign grav_en   = (state == ST_ACTIVE) || (state == ST_PROBE);
  // Spawn restarts the gravity period so a fresh piece always gets a full tick.
  assign timer_rst = rst | spawn;

  gravity_timer #(
    .GRAVITY_DIV(GRAVITY_DIV)
  ) u_gravity (
    .clk    (clk),
    .rst    (timer_rst),
    .en     (grav_en),
    .consume(consume),
    .pending(pending)
  );

  assign probe_valid = (state == ST_PROBE);
  assign active      = (state != ST_IDLE);
  assign landed      = (state == ST_LAND);

  always_comb begin
    state_nxt     = state;
    kind_nxt      = kind;
    pos_x_nxt     = pos_x;
    pos_y_nxt     = pos_y;
    rot_nxt       = rot;
    probe_x_nxt   = probe_x;
    probe_y_nxt   = probe_y;
    probe_rot_nxt = probe_rot;
    consume       = 1'b0;
    if (spawn) begin
      state_nxt = ST_ACTIVE;
      pos_x_nxt = X_SPAWN;
      pos_y_nxt = Y_SPAWN;
      rot_nxt   = '0;
    end else begin
      case (state)
        ST_ACTIVE: begin
          // Edge moves are rejected locally so no wrapped coordinate is probed.
          if (pending || drop) begin
            consume = 1'b1;
            if (pos_y == Y_MAX) begin
              state_nxt = ST_LAND;
            end else begin
              probe_x_nxt   = pos_x;
              probe_y_nxt   = pos_y + 1'b1;
              probe_rot_nxt = rot;
              kind_nxt      = MV_DOWN;
              state_nxt     = ST_PROBE;
            end
          end else if (left) begin
            if (pos_x != '0) begin
              probe_x_nxt   = pos_x - 1'b1;
              probe_y_nxt   = pos_y;
              probe_rot_nxt = rot;
              kind_nxt      = MV_LEFT;
              state_nxt     = ST_PROBE;
            end
          end else if (right) begin
            if (pos_x != X_MAX) begin
              probe_x_nxt   = pos_x + 1'b1;
              probe_y_nxt   = pos_y;
              probe_rot_nxt = rot;
              kind_nxt      = MV_RIGHT;
              state_nxt     = ST_PROBE;
            end
          end else if (rotate) begin
            probe_x_nxt   = pos_x;
            probe_y_nxt   = pos_y;
            probe_rot_nxt = rot + 2'd1;
            kind_nxt      = MV_ROT;
            state_nxt     = ST_PROBE;
          end
        end
        ST_PROBE: begin
          if (collide_valid) begin
            if (!collide) begin
              pos_x_nxt = probe_x;
              pos_y_nxt = probe_y;
              rot_nxt   = probe_rot;
              state_nxt = ST_ACTIVE;
            end else if (kind == MV_DOWN) begin
              state_nxt = ST_LAND;
            end else begin
              state_nxt = ST_ACTIVE;
            end
          end
        end
        ST_LAND: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      kind      <= MV_DOWN;
      pos_x     <= X_SPAWN;
      pos_y     <= Y_SPAWN;
      rot       <= '0;
      probe_x   <= '0;
      probe_y   <= '0;
      probe_rot <= '0;
    end else begin
      state     <= state_nxt;
      kind      <= kind_nxt;
      pos_x     <= pos_x_nxt;
      pos_y     <= pos_y_nxt;
      rot       <= rot_nxt;
      probe_x   <= probe_x_nxt;
      probe_y   <= probe_y_nxt;
      probe_rot <= probe_rot_nxt;
    end
  end

endmodule

// File: tb/tb_piece_pos_ctrl.sv
// Bench for piece_pos_ctrl: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the piece rules and a board responder.
module tb_piece_pos_ctrl;

  localparam int BW = 10;
  localparam int BH = 20;
  localparam int SX = 5;
  localparam int SY = 0;
  localparam int GDIV = 4;

  localparam int PH_IDLE = 0, PH_PLAY = 1, PH_WAIT = 2, PH_LAND = 3;

  logic       clk;
  logic       rst, spawn, left, right, rotate, drop;
  logic       collide_valid, collide;
  logic       probe_valid, active, landed;
  logic [4:0] probe_x, probe_y, pos_x, pos_y;
  logic [1:0] probe_rot, rot;

  piece_pos_ctrl #(
    .BOARD_W(BW), .BOARD_H(BH), .X_W(5), .Y_W(5),
    .SPAWN_X(SX), .SPAWN_Y(SY), .GRAVITY_DIV(GDIV)
  ) dut (
    .clk(clk), .rst(rst), .spawn(spawn), .left(left), .right(right),
    .rotate(rotate), .drop(drop), .probe_valid(probe_valid),
    .probe_x(probe_x), .probe_y(probe_y), .probe_rot(probe_rot),
    .collide_valid(collide_valid), .collide(collide),
    .pos_x(pos_x), .pos_y(pos_y), .rot(rot), .active(active), .landed(landed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model of the piece (plain integers)
  int m_ph, m_x, m_y, m_r, m_cx, m_cy, m_cr, m_cnt;
  bit m_down, m_pend;

  // Board responder knobs and state
  bit busy, lat_rand, col_rand, col_fixed, spur_en;
  int wait_left, lat_cfg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  nph;
    bit  run, tick, took_down;
    if (rst) begin
      m_ph = PH_IDLE; m_x = SX; m_y = SY; m_r = 0;
      m_cx = 0; m_cy = 0; m_cr = 0; m_down = 0; m_cnt = 0; m_pend = 0;
      return;
    end
    if (spawn) begin
      m_ph = PH_PLAY; m_x = SX; m_y = SY; m_r = 0; m_cnt = 0; m_pend = 0;
      return;
    end
    run = (m_ph == PH_PLAY) || (m_ph == PH_WAIT);
    tick = run && (m_cnt == GDIV - 1);
    took_down = 0;
    nph = m_ph;
    if (m_ph == PH_PLAY) begin
      if (m_pend || drop) begin
        took_down = 1;
        if (m_y == BH - 1) nph = PH_LAND;
        else begin m_cx = m_x; m_cy = m_y + 1; m_cr = m_r; m_down = 1; nph = PH_WAIT; end
      end else if (left) begin
        if (m_x > 0) begin m_cx = m_x - 1; m_cy = m_y; m_cr = m_r; m_down = 0; nph = PH_WAIT; end
      end else if (right) begin
        if (m_x < BW - 1) begin m_cx = m_x + 1; m_cy = m_y; m_cr = m_r; m_down = 0; nph = PH_WAIT; end
      end else if (rotate) begin
        m_cx = m_x; m_cy = m_y; m_cr = (m_r + 1) % 4; m_down = 0; nph = PH_WAIT;
      end
    end else if (m_ph == PH_WAIT) begin
      if (collide_valid) begin
        if (!collide) begin m_x = m_cx; m_y = m_cy; m_r = m_cr; nph = PH_PLAY; end
        else nph = m_down ? PH_LAND : PH_PLAY;
      end
    end else if (m_ph == PH_LAND) begin
      nph = PH_IDLE;
    end
    if (run) m_cnt = tick ? 0 : m_cnt + 1;
    m_pend = tick || (m_pend && !took_down);
    m_ph = nph;
  endtask

  task automatic compare_all();
    chk("active", 32'(active), 32'(m_ph != PH_IDLE));
    chk("landed", 32'(landed), 32'(m_ph == PH_LAND));
    chk("probe_valid", 32'(probe_valid), 32'(m_ph == PH_WAIT));
    chk("pos_x", 32'(pos_x), 32'(m_x));
    chk("pos_y", 32'(pos_y), 32'(m_y));
    chk("rot", 32'(rot), 32'(m_r));
    chk("probe_x", 32'(probe_x), 32'(m_cx));
    chk("probe_y", 32'(probe_y), 32'(m_cy));
    chk("probe_rot", 32'(probe_rot), 32'(m_cr));
  endtask

  task automatic step(input bit l, input bit r, input bit ro, input bit d, input bit s);
    left = l; right = r; rotate = ro; drop = d; spawn = s;
    collide_valid = 1'b0; collide = 1'b0;
    if (probe_valid === 1'b1 && !busy) begin
      busy = 1;
      wait_left = lat_rand ? $urandom_range(1, 4) : lat_cfg;
    end
    if (busy) begin
      wait_left--;
      if (wait_left == 0) begin
        busy = 0;
        collide_valid = 1'b1;
        collide = col_rand ? ($urandom_range(0, 3) == 0) : col_fixed;
      end
    end else if (spur_en && $urandom_range(0, 29) == 0) begin
      collide_valid = 1'b1;
      collide = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; spawn = 0; left = 0; right = 0; rotate = 0; drop = 0;
    collide_valid = 0; collide = 0;
    busy = 0; lat_rand = 0; col_rand = 0; col_fixed = 0; spur_en = 0; lat_cfg = 1;
    wait_left = 0;

    // Reset values
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_pos_x", 32'(pos_x), 32'd5);
    chk("rst_pos_y", 32'(pos_y), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_probe_valid", 32'(probe_valid), 32'd0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0);

    // Spawn
    step(0, 0, 0, 0, 1);
    chk("spawn_active", 32'(active), 32'd1);
    chk("spawn_pos_x", 32'(pos_x), 32'd5);
    chk("spawn_pos_y", 32'(pos_y), 32'd0);
    chk("spawn_rot", 32'(rot), 32'd0);
    chk("spawn_landed", 32'(landed), 32'd0);

    // Left held into the wall, with gravity interleaved
    repeat (30) step(1, 0, 0, 0, 0);
    chk("left_wall_x", 32'(pos_x), 32'd0);
    repeat (6) step(1, 0, 0, 0, 0);

    // Right held into the far wall
    busy = 0;
    step(0, 0, 0, 0, 1);
    repeat (30) step(0, 1, 0, 0, 0);
    chk("right_wall_x", 32'(pos_x), 32'd9);

    // Slow board (3-cycle answer) on a right move
    busy = 0; lat_cfg = 3;
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0, 0);

    // Drop blocked by the board -> one-cycle landing
    busy = 0; lat_cfg = 1; col_fixed = 1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("drop_landed", 32'(landed), 32'd1);
    chk("drop_land_y", 32'(pos_y), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("drop_landed_gone", 32'(landed), 32'd0);
    chk("drop_inactive", 32'(active), 32'd0);
    chk("drop_keep_x", 32'(pos_x), 32'd5);

    // Spawn aborts an outstanding probe; the late answer is ignored
    busy = 0; col_fixed = 0; lat_cfg = 3;
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("abort_pos_x", 32'(pos_x), 32'd5);
    chk("abort_probe_off", 32'(probe_valid), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("late_ignored_x", 32'(pos_x), 32'd5);
    step(0, 0, 0, 0, 0);

    // Gravity alone down to the floor, then gravity racing a held left
    busy = 0; lat_cfg = 1;
    step(0, 0, 0, 0, 1);
    repeat (120) step(0, 0, 0, 0, 0);
    chk("floor_inactive", 32'(active), 32'd0);
    chk("floor_y", 32'(pos_y), 32'(BH - 1));
    step(0, 0, 0, 0, 1);
    repeat (20) step(1, 0, 0, 0, 0);
    repeat (8) step(0, 0, 1, 0, 0);

    // Random traffic
    lat_rand = 1; col_rand = 1; spur_en = 1;
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
           (active === 1'b1) ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 3) == 0));
    end
    rst = 1'b0;
    step(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
